// File: rtl/ppu_mem_responder_if.sv
// PPU/CPU request bus for the VRAM/OAM responder.
// master: requesters (PPU fetch + CPU); slave: the memory responder.
interface ppu_mem_responder_if;
  logic        lcd_en_in;
  logic [1:0]  ppu_mode_in;
  logic        ppu_req_in;
  logic [15:0] ppu_addr_in;
  logic [7:0]  ppu_data_out;
  logic        ppu_data_valid_out;
  logic        cpu_req_in;
  logic        cpu_we_in;
  logic [15:0] cpu_addr_in;
  logic [7:0]  cpu_wdata_in;
  logic [7:0]  cpu_rdata_out;
  logic        cpu_ack_out;

  modport master (
    output lcd_en_in, ppu_mode_in,
    output ppu_req_in, ppu_addr_in,
    input  ppu_data_out, ppu_data_valid_out,
    output cpu_req_in, cpu_we_in, cpu_addr_in, cpu_wdata_in,
    input  cpu_rdata_out, cpu_ack_out
  );

  modport slave (
    input  lcd_en_in, ppu_mode_in,
    input  ppu_req_in, ppu_addr_in,
    output ppu_data_out, ppu_data_valid_out,
    input  cpu_req_in, cpu_we_in, cpu_addr_in, cpu_wdata_in,
    output cpu_rdata_out, cpu_ack_out
  );
endinterface

// File: rtl/ppu_mem_responder.sv
// VRAM/OAM responder: fixed-latency pipelined PPU reads (port A) and
// mode-gated CPU reads/writes (port B) over shared dual-port byte RAMs.
module ppu_mem_responder #(
  parameter int VRAM_DEPTH   = 8192,
  parameter int OAM_DEPTH    = 160,
  parameter int READ_LATENCY = 2
) (
  input  logic              clk_in,
  input  logic              rst_in,
  ppu_mem_responder_if.slave bus
);
  localparam int DATA_W = 8;
  localparam int VA_W   = $clog2(VRAM_DEPTH);
  localparam int OA_W   = $clog2(OAM_DEPTH);
  localparam logic [15:0] VRAM_BASE = 16'h8000;
  localparam logic [15:0] OAM_BASE  = 16'hFE00;
  localparam logic [15:0] VRAM_END  = 16'(32'h8000 + VRAM_DEPTH - 1);
  localparam logic [15:0] OAM_END   = 16'(32'hFE00 + OAM_DEPTH - 1);

  typedef enum logic [1:0] {SEL_VRAM, SEL_OAM, SEL_ZERO, SEL_ONES} sel_e;

  function automatic sel_e decode(input logic [15:0] addr);
    if (addr >= VRAM_BASE && addr <= VRAM_END) return SEL_VRAM;
    if (addr >= OAM_BASE && addr <= OAM_END)   return SEL_OAM;
    if (addr >= OAM_BASE && addr <= 16'hFEFF)  return SEL_ZERO;
    return SEL_ONES;
  endfunction

  // SEL_ZERO is the unusable block next to OAM, so it locks together with OAM.
  function automatic logic locked(input sel_e s, input logic lcd, input logic [1:0] mode);
    return lcd && ((mode == 2'd2 && (s == SEL_OAM || s == SEL_ZERO)) ||
                   (mode == 2'd3 && s != SEL_ONES));
  endfunction

  function automatic logic [DATA_W-1:0] pick(input sel_e s, input logic [DATA_W-1:0] vq,
                                             input logic [DATA_W-1:0] oq);
    case (s)
      SEL_VRAM: return vq;
      SEL_OAM:  return oq;
      SEL_ZERO: return '0;
      default:  return '1;
    endcase
  endfunction

  logic [DATA_W-1:0] vram [VRAM_DEPTH];
  logic [DATA_W-1:0] oam  [OAM_DEPTH];

  sel_e            ppu_sel, cpu_sel_raw, cpu_sel;
  logic            cpu_lock, cpu_wr;
  logic [VA_W-1:0] ppu_vidx, cpu_vidx;
  logic [OA_W-1:0] ppu_oidx, cpu_oidx;

  always_comb begin
    ppu_sel     = decode(bus.ppu_addr_in);
    cpu_sel_raw = decode(bus.cpu_addr_in);
    cpu_lock    = locked(cpu_sel_raw, bus.lcd_en_in, bus.ppu_mode_in);
    ppu_vidx    = (ppu_sel == SEL_VRAM)     ? VA_W'(bus.ppu_addr_in - VRAM_BASE) : '0;
    cpu_vidx    = (cpu_sel_raw == SEL_VRAM) ? VA_W'(bus.cpu_addr_in - VRAM_BASE) : '0;
    ppu_oidx    = (ppu_sel == SEL_OAM)      ? OA_W'(bus.ppu_addr_in - OAM_BASE)  : '0;
    cpu_oidx    = (cpu_sel_raw == SEL_OAM)  ? OA_W'(bus.cpu_addr_in - OAM_BASE)  : '0;
    cpu_wr      = bus.cpu_req_in && bus.cpu_we_in && !rst_in && !cpu_lock;
    if (bus.cpu_we_in)  cpu_sel = SEL_ZERO;
    else if (cpu_lock)  cpu_sel = SEL_ONES;
    else                cpu_sel = cpu_sel_raw;
  end

  // Stage p0: RAM write and registered read (read-first), decoded select.
  logic [DATA_W-1:0] ppu_vq_p0, ppu_oq_p0, cpu_vq_p0, cpu_oq_p0;
  sel_e              ppu_sel_p0, cpu_sel_p0;
  logic              ppu_vld_p0, cpu_vld_p0;

  always_ff @(posedge clk_in) begin
    if (cpu_wr && cpu_sel_raw == SEL_VRAM) vram[cpu_vidx] <= bus.cpu_wdata_in;
    if (cpu_wr && cpu_sel_raw == SEL_OAM)  oam[cpu_oidx]  <= bus.cpu_wdata_in;
    ppu_vq_p0  <= vram[ppu_vidx];
    ppu_oq_p0  <= oam[ppu_oidx];
    cpu_vq_p0  <= vram[cpu_vidx];
    cpu_oq_p0  <= oam[cpu_oidx];
    ppu_sel_p0 <= ppu_sel;
    cpu_sel_p0 <= cpu_sel;
  end

  logic [DATA_W-1:0] ppu_pick, cpu_pick;
  assign ppu_pick = pick(ppu_sel_p0, ppu_vq_p0, ppu_oq_p0);
  assign cpu_pick = pick(cpu_sel_p0, cpu_vq_p0, cpu_oq_p0);

  // Stage p1: optional extra register when READ_LATENCY is 2.
  logic [DATA_W-1:0] ppu_dat_p1, cpu_dat_p1;
  logic              ppu_vld_p1, cpu_vld_p1;

  always_ff @(posedge clk_in) begin
    ppu_dat_p1 <= ppu_pick;
    cpu_dat_p1 <= cpu_pick;
  end

  logic [DATA_W-1:0] ppu_fin, cpu_fin;
  logic              ppu_fin_vld, cpu_fin_vld;
  assign ppu_fin     = (READ_LATENCY == 1) ? ppu_pick   : ppu_dat_p1;
  assign cpu_fin     = (READ_LATENCY == 1) ? cpu_pick   : cpu_dat_p1;
  assign ppu_fin_vld = (READ_LATENCY == 1) ? ppu_vld_p0 : ppu_vld_p1;
  assign cpu_fin_vld = (READ_LATENCY == 1) ? cpu_vld_p0 : cpu_vld_p1;

  // Output stage; reset flushes every in-flight request.
  logic [DATA_W-1:0] ppu_data_q, cpu_rdata_q;
  logic              ppu_vld_q, cpu_ack_q;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      ppu_vld_p0  <= 1'b0;
      cpu_vld_p0  <= 1'b0;
      ppu_vld_p1  <= 1'b0;
      cpu_vld_p1  <= 1'b0;
      ppu_vld_q   <= 1'b0;
      cpu_ack_q   <= 1'b0;
      ppu_data_q  <= '0;
      cpu_rdata_q <= '0;
    end else begin
      ppu_vld_p0 <= bus.ppu_req_in;
      cpu_vld_p0 <= bus.cpu_req_in;
      ppu_vld_p1 <= ppu_vld_p0;
      cpu_vld_p1 <= cpu_vld_p0;
      ppu_vld_q  <= ppu_fin_vld;
      cpu_ack_q  <= cpu_fin_vld;
      if (ppu_fin_vld) ppu_data_q  <= ppu_fin;
      if (cpu_fin_vld) cpu_rdata_q <= cpu_fin;
    end
  end

  assign bus.ppu_data_out       = ppu_data_q;
  assign bus.ppu_data_valid_out = ppu_vld_q;
  assign bus.cpu_rdata_out      = cpu_rdata_q;
  assign bus.cpu_ack_out        = cpu_ack_q;
endmodule
